// File: rtl/comet_mem_pkg.sv
// ---------------------------------------------------------------------------
// comet_mem_pkg
// Shared definitions for the COMET II test-RAM arbiter slice.
//   state_e  : arbiter FSM encoding (IDLE / ACCESS / DONE)
//   M_CPU    : master index of the CPU bus
//   M_LDR    : master index of the program loader / debug port
//   MEM_AW   : default number of implemented RAM address bits (256 words)
//   CNT_W    : width of the wait-state counter (WAIT_CYCLES is 0..15)
// ---------------------------------------------------------------------------
package comet_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic M_CPU = 1'b0;
    localparam logic M_LDR = 1'b1;

    localparam int MEM_AW = 8;
    localparam int CNT_W  = 4;

endpackage

// File: rtl/comet_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// comet_mem_arbiter_if
// Bundles the two requester ports, the RAM-side port and the busy flag.
//   m0_* : CPU bus          (req/we/addr/wdata in, ack/err/rdata out)
//   m1_* : loader/debug port (same shape as m0_*)
//   mem_*: single-port RAM  (we/waddr/wdata/re/raddr out, rdata in)
//   busy : arbiter is not idle
// Modport slave is the arbiter's view; modport master is everything else
// (requesters plus RAM), as seen from outside the arbiter.
// ---------------------------------------------------------------------------
interface comet_mem_arbiter_if #(
    parameter int DW = 16,
    parameter int AW = 16
) ();

    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_ack;
    logic          m0_err;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_ack;
    logic          m1_err;
    logic [DW-1:0] m1_rdata;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          mem_re;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_err, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_err, m1_rdata,
        output mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr,
        input  mem_rdata,
        output busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_err, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_err, m1_rdata,
        input  mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr,
        output mem_rdata,
        input  busy
    );

endinterface

// File: rtl/comet_rr_arb2.sv
// ---------------------------------------------------------------------------
// comet_rr_arb2
// Two-way round-robin grant logic.
//   mclk, rst   : clock, asynchronous active-high reset
//   req0, req1  : request lines of master 0 (CPU) and master 1 (loader)
//   grant_en    : commit the current grant (updates last-grant history)
//   grant_valid : at least one request is present
//   grant_idx   : index of the master that wins this cycle
// On a tie the master opposite the last committed grant wins. History resets
// to M_LDR so the CPU wins the first tie after reset.
// ---------------------------------------------------------------------------
module comet_rr_arb2 (
    input  logic mclk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic grant_en,
    output logic grant_valid,
    output logic grant_idx
);
    import comet_mem_pkg::*;

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant_valid  = req0 | req1;
        grant_idx    = M_CPU;
        last_grant_d = last_grant_q;
        if (req0 && req1) begin
            grant_idx = (last_grant_q == M_CPU) ? M_LDR : M_CPU;
        end else if (req1) begin
            grant_idx = M_LDR;
        end
        if (grant_en && grant_valid) begin
            last_grant_d = grant_idx;
        end
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            last_grant_q <= M_LDR;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/comet_mem_arbiter.sv
// ---------------------------------------------------------------------------
// comet_mem_arbiter
// Two-master arbiter and access sequencer for the 256-word COMET II test RAM.
//   mclk : system clock (rising-edge logic; the RAM writes on the negedge)
//   rst  : asynchronous active-high reset
//   bus  : comet_mem_arbiter_if.slave carrying both requester ports, the RAM
//          port and busy
// Parameters: DW data width, AW requester address width, MEM_AW implemented
// RAM address bits, WAIT_CYCLES extra ACCESS cycles per transaction (0..15).
// Each transaction runs IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> DONE.
// Addresses beyond the RAM are flagged with err and never reach the RAM.
// ---------------------------------------------------------------------------
module comet_mem_arbiter #(
    parameter int DW          = 16,
    parameter int AW          = 16,
    parameter int MEM_AW      = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic               mclk,
    input  logic               rst,
    comet_mem_arbiter_if.slave bus
);
    import comet_mem_pkg::*;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              gnt_q,   gnt_d;
    logic              we_q,    we_d;
    logic [AW-1:0]     addr_q,  addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW-1:0]     rdata0_q, rdata0_d;
    logic [DW-1:0]     rdata1_q, rdata1_d;

    logic arb_en;
    logic arb_valid;
    logic arb_idx;
    logic out_of_range;
    logic last_access;

    comet_rr_arb2 u_arb (
        .mclk        (mclk),
        .rst         (rst),
        .req0        (bus.m0_req),
        .req1        (bus.m1_req),
        .grant_en    (arb_en),
        .grant_valid (arb_valid),
        .grant_idx   (arb_idx)
    );

    // Any set bit above the implemented RAM range means the access must not
    // alias into the RAM.
    assign out_of_range = (addr_q >> MEM_AW) != '0;
    assign last_access  = (cnt_q == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        arb_en   = 1'b0;

        unique case (state_q)
            IDLE: begin
                arb_en = 1'b1;
                if (arb_valid) begin
                    gnt_d = arb_idx;
                    if (arb_idx == M_LDR) begin
                        we_d    = bus.m1_we;
                        addr_d  = bus.m1_addr;
                        wdata_d = bus.m1_wdata;
                    end else begin
                        we_d    = bus.m0_we;
                        addr_d  = bus.m0_addr;
                        wdata_d = bus.m0_wdata;
                    end
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (last_access) begin
                    state_d = DONE;
                    // mem_rdata is only trusted here; out-of-range reads
                    // return zero rather than whatever the RAM presents.
                    if (!we_q) begin
                        if (gnt_q == M_LDR) begin
                            rdata1_d = out_of_range ? '0 : bus.mem_rdata;
                        end else begin
                            rdata0_d = out_of_range ? '0 : bus.mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            gnt_q    <= M_CPU;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Strobes decode straight from the state register so they fall the
    // moment rst lands; a write only strobes in the final ACCESS cycle so
    // the RAM commits it exactly once on that cycle's negedge.
    always_comb begin
        bus.mem_re = 1'b0;
        bus.mem_we = 1'b0;
        bus.m0_ack = 1'b0;
        bus.m0_err = 1'b0;
        bus.m1_ack = 1'b0;
        bus.m1_err = 1'b0;
        if (state_q == ACCESS && !out_of_range) begin
            bus.mem_re = !we_q;
            bus.mem_we = we_q && last_access;
        end
        if (state_q == DONE) begin
            if (gnt_q == M_LDR) begin
                bus.m1_ack = 1'b1;
                bus.m1_err = out_of_range;
            end else begin
                bus.m0_ack = 1'b1;
                bus.m0_err = out_of_range;
            end
        end
    end

    assign bus.mem_raddr = addr_q;
    assign bus.mem_waddr = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_rdata  = rdata1_q;
    assign bus.busy      = (state_q != IDLE);

endmodule
